// File: rtl/svn_pkg.sv
// Shared definitions for the 7-segment bus: segment patterns (active low, {CA..CG}),
// capture FSM encoding and the pattern-decoder result type.
package svn_pkg;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b1110010;
    localparam logic [6:0] SEG_B = 7'b1100110;
    localparam logic [6:0] SEG_C = 7'b1011100;
    localparam logic [6:0] SEG_D = 7'b0110100;
    localparam logic [6:0] SEG_E = 7'b1100000;
    localparam logic [6:0] SEG_F = 7'b1111111;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    typedef struct packed {
        logic       hit;
        logic [3:0] hex;
    } pat_dec_t;

endpackage

// File: rtl/svn_pat_dec.sv
// Combinational segment-pattern decoder: exact match of the active-low segment
// vector against the hex glyph table; anything else reports no hit.
module svn_pat_dec
    import svn_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic       o_hit,
    output logic [3:0] o_hex
);

    // Exact-match table lookup; unknown glyphs fall to the miss branch
    always_comb begin
        o_hit = 1'b1;
        o_hex = 4'h0;
        case (i_seg)
            SEG_0:   o_hex = 4'h0;
            SEG_1:   o_hex = 4'h1;
            SEG_2:   o_hex = 4'h2;
            SEG_3:   o_hex = 4'h3;
            SEG_4:   o_hex = 4'h4;
            SEG_5:   o_hex = 4'h5;
            SEG_6:   o_hex = 4'h6;
            SEG_7:   o_hex = 4'h7;
            SEG_8:   o_hex = 4'h8;
            SEG_9:   o_hex = 4'h9;
            SEG_A:   o_hex = 4'hA;
            SEG_B:   o_hex = 4'hB;
            SEG_C:   o_hex = 4'hC;
            SEG_D:   o_hex = 4'hD;
            SEG_E:   o_hex = 4'hE;
            SEG_F:   o_hex = 4'hF;
            default: begin
                o_hit = 1'b0;
                o_hex = 4'h0;
            end
        endcase
    end

endmodule

// File: rtl/svn_seg_capture.sv
// Receive side of the multiplexed 7-segment bus: synchronises AN/CA..CG/DP, waits for
// the bus to settle on a single active anode, and captures that digit into a register bank.
module svn_seg_capture
    import svn_pkg::*;
#(
    parameter int N_DIGITS   = 8,
    parameter int SETTLE_CYC = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_DIGITS-1:0]     an_in,
    input  logic [6:0]              seg_in,
    input  logic                    dp_in,
    output logic [4*N_DIGITS-1:0]   digits_o,
    output logic [N_DIGITS-1:0]     dp_o,
    output logic [N_DIGITS-1:0]     valid_o,
    output logic                    frame_done_o,
    output logic                    err_o
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CNT_W = $clog2(SETTLE_CYC + 1);

    logic [N_DIGITS-1:0]   r_an_s1, r_an_s2;
    logic [6:0]            r_seg_s1, r_seg_s2;
    logic                  r_dp_s1, r_dp_s2;
    logic [CNT_W-1:0]      r_cnt;
    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [IDX_W-1:0]      r_cap_idx;
    logic [6:0]            r_cap_seg;
    logic                  r_cap_dp;
    logic [N_DIGITS-1:0]   r_seen;
    logic [4*N_DIGITS-1:0] r_digits;
    logic [N_DIGITS-1:0]   r_dp;
    logic [N_DIGITS-1:0]   r_valid;
    logic                  r_frame_done;
    logic                  r_err;

    logic                  w_changed;
    logic                  w_settled;
    logic                  w_any_low;
    logic                  w_multi_low;
    logic                  w_one_low;
    logic [IDX_W-1:0]      w_idx;
    logic [N_DIGITS-1:0]   w_cap_oh;
    pat_dec_t              w_dec;

    // Two-flop synchroniser; idles at the inactive (all-high) bus level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an_s1  <= {N_DIGITS{1'b1}};
            r_an_s2  <= {N_DIGITS{1'b1}};
            r_seg_s1 <= 7'h7F;
            r_seg_s2 <= 7'h7F;
            r_dp_s1  <= 1'b1;
            r_dp_s2  <= 1'b1;
        end else begin
            r_an_s1  <= an_in;
            r_an_s2  <= r_an_s1;
            r_seg_s1 <= seg_in;
            r_seg_s2 <= r_seg_s1;
            r_dp_s1  <= dp_in;
            r_dp_s2  <= r_dp_s1;
        end
    end

    // A difference between the two stages means the synchronised copy changes next cycle
    assign w_changed = ({r_an_s1, r_seg_s1, r_dp_s1} != {r_an_s2, r_seg_s2, r_dp_s2});
    assign w_settled = (r_cnt >= CNT_W'(SETTLE_CYC - 1));
    assign w_one_low = w_any_low & ~w_multi_low;

    // Active-anode detection: first low bit gives the slot index, a second one flags contention
    always_comb begin
        w_any_low   = 1'b0;
        w_multi_low = 1'b0;
        w_idx       = {IDX_W{1'b0}};
        for (int k = 0; k < N_DIGITS; k++) begin
            w_multi_low = w_multi_low | (~r_an_s2[k] & w_any_low);
            if (!r_an_s2[k] && !w_any_low) begin
                w_idx = IDX_W'(k);
            end else begin
                w_idx = w_idx;
            end
            w_any_low = w_any_low | ~r_an_s2[k];
        end
    end

    // Settle counter: restarts on any bus change, saturates at SETTLE_CYC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_changed) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (r_cnt < CNT_W'(SETTLE_CYC)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Capture FSM next-state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_changed && w_one_low) w_state_nxt = ST_SETTLE;
                else                         w_state_nxt = ST_IDLE;
            end
            ST_SETTLE: begin
                if (w_changed)      w_state_nxt = ST_IDLE;
                else if (w_settled) w_state_nxt = ST_CAPTURE;
                else                w_state_nxt = ST_SETTLE;
            end
            ST_CAPTURE: begin
                if (w_changed) w_state_nxt = ST_IDLE;
                else           w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (w_changed) w_state_nxt = ST_IDLE;
                else           w_state_nxt = ST_HOLD;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state, contention flag and snapshot of the settled bus taken on entry to CAPTURE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_err     <= 1'b0;
            r_cap_idx <= {IDX_W{1'b0}};
            r_cap_seg <= 7'h7F;
            r_cap_dp  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= r_err | ((r_state == ST_IDLE) & ~w_changed & w_multi_low);
            if ((r_state == ST_SETTLE) && (w_state_nxt == ST_CAPTURE)) begin
                r_cap_idx <= w_idx;
                r_cap_seg <= r_seg_s2;
                r_cap_dp  <= r_dp_s2;
            end else begin
                r_cap_idx <= r_cap_idx;
                r_cap_seg <= r_cap_seg;
                r_cap_dp  <= r_cap_dp;
            end
        end
    end

    svn_pat_dec u_pat_dec (
        .i_seg (r_cap_seg),
        .o_hit (w_dec.hit),
        .o_hex (w_dec.hex)
    );

    // One-hot write strobe for the slot being captured this cycle
    always_comb begin
        w_cap_oh = {N_DIGITS{1'b0}};
        for (int k = 0; k < N_DIGITS; k++) begin
            w_cap_oh[k] = (r_state == ST_CAPTURE) && (r_cap_idx == IDX_W'(k));
        end
    end

    // Register bank; an unrecognised glyph keeps the old hex but drops valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits <= {(4*N_DIGITS){1'b0}};
            r_dp     <= {N_DIGITS{1'b0}};
            r_valid  <= {N_DIGITS{1'b0}};
        end else begin
            for (int k = 0; k < N_DIGITS; k++) begin
                if (w_cap_oh[k]) begin
                    r_digits[4*k +: 4] <= w_dec.hit ? w_dec.hex : r_digits[4*k +: 4];
                    r_valid[k]         <= w_dec.hit;
                    r_dp[k]            <= ~r_cap_dp;
                end else begin
                    r_digits[4*k +: 4] <= r_digits[4*k +: 4];
                    r_valid[k]         <= r_valid[k];
                    r_dp[k]            <= r_dp[k];
                end
            end
        end
    end

    // Frame tracking: a capture landing in the clearing cycle starts the new frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seen       <= {N_DIGITS{1'b0}};
            r_frame_done <= 1'b0;
        end else if (r_seen == {N_DIGITS{1'b1}}) begin
            r_seen       <= w_cap_oh;
            r_frame_done <= 1'b1;
        end else begin
            r_seen       <= r_seen | w_cap_oh;
            r_frame_done <= 1'b0;
        end
    end

    assign digits_o     = r_digits;
    assign dp_o         = r_dp;
    assign valid_o      = r_valid;
    assign frame_done_o = r_frame_done;
    assign err_o        = r_err;

endmodule

// File: tb/tb_svn_seg_capture.sv
// Scoreboard bench for svn_seg_capture: a bus-level model predicts the register bank,
// error flag and frame count for each driven digit; results are compared after each hold.
module tb_svn_seg_capture;

    localparam int N  = 8;
    localparam int SC = 4;
    localparam int CAP_CYC = SC + 3;

    typedef struct {
        logic [31:0] digits;
        logic [7:0]  dp;
        logic [7:0]  valid;
        logic        err;
        int          frames;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] an_in;
    logic [6:0]   seg_in;
    logic         dp_in;
    logic [4*N-1:0] digits_o;
    logic [N-1:0] dp_o;
    logic [N-1:0] valid_o;
    logic         frame_done_o;
    logic         err_o;

    always #5 clk = ~clk;

    svn_seg_capture #(.N_DIGITS(N), .SETTLE_CYC(SC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .an_in        (an_in),
        .seg_in       (seg_in),
        .dp_in        (dp_in),
        .digits_o     (digits_o),
        .dp_o         (dp_o),
        .valid_o      (valid_o),
        .frame_done_o (frame_done_o),
        .err_o        (err_o)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_frames = 0;
    int n_writes = 0;
    logic [47:0] prev_bank = 48'h0;

    logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b1110010, 7'b1100110,
                                 7'b1011100, 7'b0110100, 7'b1100000, 7'b1111111};

    logic [31:0] m_digits;
    logic [7:0]  m_dp, m_valid, m_seen;
    logic        m_err;
    int          m_frames;
    exp_t        sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: frame pulses (in cycles high) and bank-change events
    always @(negedge clk) begin
        if (frame_done_o === 1'b1) n_frames++;
        if ({digits_o, dp_o, valid_o} !== prev_bank) n_writes++;
        prev_bank = {digits_o, dp_o, valid_o};
    end

    task automatic model_reset();
        m_digits = 32'h0; m_dp = 8'h0; m_valid = 8'h0; m_seen = 8'h0;
        m_err = 1'b0;
    endtask

    task automatic model_apply(input logic [7:0] an, input logic [6:0] seg, input logic d, input int cyc);
        int lows;
        int k;
        int hex;
        lows = 0; k = 0; hex = -1;
        for (int i = 0; i < N; i++) if (!an[i]) begin lows++; k = i; end
        for (int h = 0; h < 16; h++) if (seg_tab[h] == seg) hex = h;
        if (lows == 1 && cyc >= CAP_CYC) begin
            if (hex >= 0) begin
                m_digits[4*k +: 4] = 4'(hex);
                m_valid[k] = 1'b1;
            end else begin
                m_valid[k] = 1'b0;
            end
            m_dp[k] = ~d;
            m_seen[k] = 1'b1;
            if (m_seen == 8'hFF) begin
                m_frames++;
                m_seen = 8'h00;
            end
        end else if (lows > 1 && cyc >= 3) begin
            m_err = 1'b1;
        end
    endtask

    task automatic push_expect();
        exp_t e;
        e.digits = m_digits; e.dp = m_dp; e.valid = m_valid; e.err = m_err; e.frames = m_frames;
        sb.push_back(e);
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_underflow"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_digits"}, 64'(digits_o), 64'(e.digits));
            check({tag, "_dp"},     64'(dp_o),     64'(e.dp));
            check({tag, "_valid"},  64'(valid_o),  64'(e.valid));
            check({tag, "_err"},    64'(err_o),    64'(e.err));
            check({tag, "_frames"}, 64'(n_frames), 64'(e.frames));
        end
    endtask

    task automatic step(input string tag, input logic [7:0] an, input logic [6:0] seg, input logic d, input int cyc);
        an_in = an; seg_in = seg; dp_in = d;
        model_apply(an, seg, d, cyc);
        push_expect();
        repeat (cyc) @(posedge clk);
        @(negedge clk); #1;
        sb_check(tag);
    endtask

    task automatic scan(input string tag);
        for (int h = 0; h < N; h++) begin
            step($sformatf("%s_d%0d", tag, h), ~(8'h01 << h), seg_tab[h], (h == 5) ? 1'b0 : 1'b1, SC + 4);
        end
    endtask

    int w0, f0;

    initial begin
        rst_n = 1'b0; an_in = 8'hFF; seg_in = 7'h7F; dp_in = 1'b1;
        model_reset(); m_frames = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: idle bus after reset
        w0 = n_writes;
        step("t1_idle", 8'hFF, 7'h7F, 1'b1, 100);
        check("t1_frame_done", 64'(frame_done_o), 64'd0);
        check("t1_writes", 64'(n_writes - w0), 64'd0);

        // 2: single digit, single write
        w0 = n_writes;
        step("t2", 8'hFE, 7'b0000110, 1'b1, 10);
        check("t2_digit0", 64'(digits_o[3:0]), 64'd3);
        check("t2_writes", 64'(n_writes - w0), 64'd1);

        // 3: full scan
        f0 = n_frames;
        scan("t3");
        check("t3_digits", 64'(digits_o), 64'h76543210);
        check("t3_dp", 64'(dp_o), 64'h20);
        check("t3_valid", 64'(valid_o), 64'hFF);
        check("t3_frame_pulses", 64'(n_frames - f0), 64'd1);

        // 4: unrecognised glyph on digit 1
        step("t4", 8'hFD, 7'b1111110, 1'b1, 8);
        check("t4_digit1", 64'(digits_o[7:4]), 64'd1);
        check("t4_valid1", 64'(valid_o[1]), 64'd0);

        // 5: short glitch must not write, then anode contention
        w0 = n_writes;
        step("t5_glitch", 8'hFB, seg_tab[9], 1'b1, SC - 2);
        step("t5_idle", 8'hFF, 7'h7F, 1'b1, 8);
        check("t5_glitch_writes", 64'(n_writes - w0), 64'd0);
        check("t5_digit2", 64'(digits_o[11:8]), 64'd2);
        step("t5_multi", 8'hF3, seg_tab[0], 1'b1, 8);
        step("t5_sticky", 8'hFF, 7'h7F, 1'b1, 8);
        check("t5_err_sticky", 64'(err_o), 64'd1);

        // 6: reset during HOLD after a partial frame, then one clean frame
        step("t6_a", 8'hFE, seg_tab[10], 1'b0, 8);
        step("t6_b", 8'hFD, seg_tab[11], 1'b1, 8);
        rst_n = 1'b0;
        an_in = 8'hFF; seg_in = 7'h7F; dp_in = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        push_expect();
        @(negedge clk); #1;
        sb_check("t6_reset");
        f0 = n_frames;
        scan("t6_scan");
        check("t6_frame_pulses", 64'(n_frames - f0), 64'd1);
        check("t6_err_cleared", 64'(err_o), 64'd0);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
